// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: datapath width, fetch FSM states,
// reset PC default and the IF/ID register payload.
package mips_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP              = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    HOLD    = 2'd2,
    DISCARD = 2'd3
  } if_state_e;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] instr;
  } ifid_t;

  // Word-aligns a target address by clearing its byte-offset bits.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory request/response bundle between the fetch stage
// (master) and the instruction memory (slave).
interface if_stage_if;

  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ready_i;
  logic [31:0] imem_rdata_i;

  modport master (
    output imem_req_o,
    output imem_addr_o,
    input  imem_ready_i,
    input  imem_rdata_i
  );

  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    output imem_ready_i,
    output imem_rdata_i
  );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Priority: flush (clear valid) > load > hold;
// with no control asserted it inserts a bubble (valid cleared, fields kept).
module if_id_reg
  import mips_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  load_i,
  input  logic  flush_i,
  input  logic  hold_i,
  input  ifid_t data_i,
  output ifid_t q_o
);

  ifid_t ifid_q;
  ifid_t ifid_d;

  always_comb begin
    ifid_d = ifid_q;
    if (flush_i) begin
      ifid_d.valid = 1'b0;
    end else if (load_i) begin
      ifid_d = data_i;
    end else if (!hold_i) begin
      ifid_d.valid = 1'b0;
    end
  end

  // NOTE: state flops use non-blocking (<=) so every register samples its
  // inputs as they were before the edge; blocking here would create
  // order-dependent simulation and sim/synth mismatches.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ifid_q <= '{valid: 1'b0, pc: '0, pc4: '0, instr: NOP};
    end else begin
      ifid_q <= ifid_d;
    end
  end

  assign q_o = ifid_q;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC, fetch FSM, one-entry skid buffer and IF/ID.
// Optional fetch counter output enabled by defining IF_FETCH_CNT_EN.
module if_stage
  import mips_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  if_stage_if.master      imem,
  output logic            ifid_valid_o,
  output logic [XLEN-1:0] ifid_pc_o,
  output logic [XLEN-1:0] ifid_pc4_o,
  output logic [XLEN-1:0] ifid_instr_o
`ifdef IF_FETCH_CNT_EN
  ,
  output logic [XLEN-1:0] fetch_count_o
`endif
);

  if_state_e       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_addr_q, req_addr_d;
  logic [XLEN-1:0] skid_q, skid_d;
  logic            skid_valid_q, skid_valid_d;

  logic            ifid_load;
  logic            ifid_flush;
  logic            ifid_hold;
  ifid_t           ifid_in;
  ifid_t           ifid_out;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] redirect_target;
  logic            unused_redirect_lsbs;

  assign pc_plus4             = pc_q + 32'd4;
  assign redirect_target      = word_align(redirect_pc_i);
  assign unused_redirect_lsbs = ^redirect_pc_i[1:0];

  // NOTE: every signal written below gets a default first, so no path
  // through the case leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_addr_d   = req_addr_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    ifid_load    = 1'b0;
    ifid_flush   = 1'b0;
    ifid_hold    = 1'b0;
    ifid_in      = '{valid: 1'b1, pc: pc_q, pc4: pc_plus4, instr: imem.imem_rdata_i};
    imem_req     = 1'b0;
    imem_addr    = pc_q;

    case (state_q)
      IDLE: begin
        ifid_flush = 1'b1;
        state_d    = FETCH;
        if (redirect_i) begin
          pc_d = redirect_target;
        end
      end

      FETCH: begin
        imem_req = 1'b1;
        if (redirect_i) begin
          pc_d         = redirect_target;
          ifid_flush   = 1'b1;
          skid_valid_d = 1'b0;
          if (!imem.imem_ready_i) begin
            // The memory still owes a word for the old PC; wait it out.
            state_d    = DISCARD;
            req_addr_d = pc_q;
          end
        end else if (imem.imem_ready_i && !stall_i) begin
          ifid_load = 1'b1;
          pc_d      = pc_plus4;
        end else if (imem.imem_ready_i) begin
          skid_d       = imem.imem_rdata_i;
          skid_valid_d = 1'b1;
          ifid_hold    = 1'b1;
          state_d      = HOLD;
        end else if (stall_i) begin
          ifid_hold = 1'b1;
        end
      end

      HOLD: begin
        if (redirect_i) begin
          pc_d         = redirect_target;
          ifid_flush   = 1'b1;
          skid_valid_d = 1'b0;
          state_d      = FETCH;
        end else if (!stall_i && skid_valid_q) begin
          ifid_in.instr = skid_q;
          ifid_load     = 1'b1;
          pc_d          = pc_plus4;
          skid_valid_d  = 1'b0;
          state_d       = FETCH;
        end else begin
          ifid_hold = 1'b1;
        end
      end

      DISCARD: begin
        imem_req   = 1'b1;
        imem_addr  = req_addr_q;
        ifid_flush = 1'b1;
        if (redirect_i) begin
          pc_d = redirect_target;
        end
        if (imem.imem_ready_i) begin
          state_d = FETCH;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: the skid buffer is a single register, not a memory array, so it
  // is cheap to reset and gets a defined NOP value alongside its valid bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      req_addr_q   <= RESET_PC;
      skid_q       <= NOP;
      skid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_addr_q   <= req_addr_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  if_id_reg u_if_id_reg (
    .clk     (clk),
    .reset   (reset),
    .load_i  (ifid_load),
    .flush_i (ifid_flush),
    .hold_i  (ifid_hold),
    .data_i  (ifid_in),
    .q_o     (ifid_out)
  );

  assign imem.imem_req_o  = imem_req;
  assign imem.imem_addr_o = imem_addr;

  assign ifid_valid_o = ifid_out.valid;
  assign ifid_pc_o    = ifid_out.pc;
  assign ifid_pc4_o   = ifid_out.pc4;
  assign ifid_instr_o = ifid_out.instr;

`ifdef IF_FETCH_CNT_EN
  logic [XLEN-1:0] fetch_count_q, fetch_count_d;

  assign fetch_count_d = ifid_load ? fetch_count_q + 32'd1 : fetch_count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_count_q <= '0;
    end else begin
      fetch_count_q <= fetch_count_d;
    end
  end

  assign fetch_count_o = fetch_count_q;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: expected IF/ID loads go into a scoreboard
// queue and a negedge monitor pops/compares each new valid IF/ID entry.
module tb_if_stage;
  import mips_pkg::*;

  localparam logic [31:0] KEY   = 32'hA5A5_0000;
  localparam logic [31:0] STALE = 32'hDEAD_BEEF;

  logic        clk;
  logic        reset;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        ifid_valid_o;
  logic [31:0] ifid_pc_o;
  logic [31:0] ifid_pc4_o;
  logic [31:0] ifid_instr_o;
  logic        stale_en;
`ifdef IF_FETCH_CNT_EN
  logic [31:0] fetch_count;
`endif

  int checks = 0;
  int errors = 0;

  ifid_t exp_q[$];
  logic        prev_valid = 1'b0;
  logic [31:0] prev_pc    = '0;

  if_stage_if imem_bus ();

  // Memory model: returns addr ^ KEY, or a stale word when asked to.
  assign imem_bus.imem_rdata_i = stale_en ? STALE : (imem_bus.imem_addr_o ^ KEY);

  if_stage dut (
    .clk           (clk),
    .reset         (reset),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem          (imem_bus),
    .ifid_valid_o  (ifid_valid_o),
    .ifid_pc_o     (ifid_pc_o),
    .ifid_pc4_o    (ifid_pc4_o),
    .ifid_instr_o  (ifid_instr_o)
`ifdef IF_FETCH_CNT_EN
    ,
    .fetch_count_o (fetch_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] pc);
    ifid_t e;
    e.valid = 1'b1;
    e.pc    = pc;
    e.pc4   = pc + 32'd4;
    e.instr = pc ^ KEY;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: a new entry is a valid IF/ID whose PC differs from the one
  // seen last cycle (held entries during a stall are not re-checked).
  always @(negedge clk) begin
    if (reset && ifid_valid_o && (!prev_valid || ifid_pc_o != prev_pc)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ifid: got pc %h with empty scoreboard", ifid_pc_o);
      end else begin
        ifid_t e;
        e = exp_q.pop_front();
        check("ifid_pc", ifid_pc_o, e.pc);
        check("ifid_pc4", ifid_pc4_o, e.pc4);
        check("ifid_instr", ifid_instr_o, e.instr);
      end
    end
    prev_valid = reset && ifid_valid_o;
    prev_pc    = ifid_pc_o;
  end

  initial begin
    reset = 1'b0;
    stall_i = 1'b0;
    redirect_i = 1'b0;
    redirect_pc_i = '0;
    imem_bus.imem_ready_i = 1'b0;
    stale_en = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req", {31'd0, imem_bus.imem_req_o}, 32'd0);
    check("rst_valid", {31'd0, ifid_valid_o}, 32'd0);
    check("rst_pc", ifid_pc_o, 32'd0);
    check("rst_pc4", ifid_pc4_o, 32'd0);
    check("rst_instr", ifid_instr_o, 32'd0);
`ifdef IF_FETCH_CNT_EN
    check("rst_cnt", fetch_count, 32'd0);
`endif

    // Streaming fetch, ready every cycle
    tick();
    reset = 1'b1;
    imem_bus.imem_ready_i = 1'b1;
    push_exp(32'h0);
    push_exp(32'h4);
    @(negedge clk);
    check("idle_req", {31'd0, imem_bus.imem_req_o}, 32'd0);
    tick();                                  // IDLE -> FETCH
    @(negedge clk);
    check("fetch0_req", {31'd0, imem_bus.imem_req_o}, 32'd1);
    check("fetch0_addr", imem_bus.imem_addr_o, 32'h0);
    check("fetch0_valid", {31'd0, ifid_valid_o}, 32'd0);
    tick();                                  // load PC 0
    @(negedge clk);
    check("fetch1_addr", imem_bus.imem_addr_o, 32'h4);
    tick();                                  // load PC 4

    // Stall for three cycles with the PC=8 word ready
    stall_i = 1'b1;
    push_exp(32'h8);
    @(negedge clk);
    check("stall_addr", imem_bus.imem_addr_o, 32'h8);
    tick();                                  // capture into skid, HOLD
    @(negedge clk);
    check("hold_req", {31'd0, imem_bus.imem_req_o}, 32'd0);
    check("hold_pc", ifid_pc_o, 32'h4);
    check("hold_valid", {31'd0, ifid_valid_o}, 32'd1);
    tick();
    @(negedge clk);
    check("hold2_pc", ifid_pc_o, 32'h4);
    tick();
    stall_i = 1'b0;
    tick();                                  // skid word PC 8 loads

    // Redirect while the request is outstanding
    imem_bus.imem_ready_i = 1'b0;
    redirect_i = 1'b1;
    redirect_pc_i = 32'h0000_0103;
    @(negedge clk);
    check("pre_redir_addr", imem_bus.imem_addr_o, 32'hC);
    tick();                                  // -> DISCARD
    redirect_i = 1'b0;
    @(negedge clk);
    check("disc_req", {31'd0, imem_bus.imem_req_o}, 32'd1);
    check("disc_addr", imem_bus.imem_addr_o, 32'hC);
    check("disc_valid", {31'd0, ifid_valid_o}, 32'd0);
    tick();
    imem_bus.imem_ready_i = 1'b1;            // old word returns, dropped
    push_exp(32'h100);
    @(negedge clk);
    check("disc2_addr", imem_bus.imem_addr_o, 32'hC);
    tick();                                  // -> FETCH at 0x100
    @(negedge clk);
    check("redir_addr", imem_bus.imem_addr_o, 32'h100);
    check("redir_valid", {31'd0, ifid_valid_o}, 32'd0);
    tick();                                  // load 0x100

    // Redirect and stall together with ready: flush wins
    redirect_i = 1'b1;
    stall_i = 1'b1;
    redirect_pc_i = 32'h40;
    tick();
    redirect_i = 1'b0;
    stall_i = 1'b0;
    push_exp(32'h40);
    @(negedge clk);
    check("flush_valid", {31'd0, ifid_valid_o}, 32'd0);
    check("flush_addr", imem_bus.imem_addr_o, 32'h40);
    tick();                                  // load 0x40

    // Redirect to the top word; PC+4 wraps
    redirect_i = 1'b1;
    redirect_pc_i = 32'hFFFF_FFFC;
    tick();
    redirect_i = 1'b0;
    push_exp(32'hFFFF_FFFC);
    @(negedge clk);
    check("top_addr", imem_bus.imem_addr_o, 32'hFFFF_FFFC);
    check("top_valid", {31'd0, ifid_valid_o}, 32'd0);
    tick();                                  // load 0xFFFFFFFC
    push_exp(32'h0);
    @(negedge clk);
    check("wrap_pc4", ifid_pc4_o, 32'h0);
    check("wrap_addr", imem_bus.imem_addr_o, 32'h0);
    tick();                                  // load 0

    // Stall with no word holds; then a bubble
    stall_i = 1'b1;
    imem_bus.imem_ready_i = 1'b0;
    tick();
    @(negedge clk);
    check("nostall_valid", {31'd0, ifid_valid_o}, 32'd1);
    check("nostall_pc", ifid_pc_o, 32'h0);
    check("nostall_addr", imem_bus.imem_addr_o, 32'h4);
    stall_i = 1'b0;
    tick();
    @(negedge clk);
    check("bubble_valid", {31'd0, ifid_valid_o}, 32'd0);
    check("bubble_pc", ifid_pc_o, 32'h0);
    check("bubble_instr", ifid_instr_o, 32'hA5A5_0000);

    // Reset mid-request; a stale word arrives after release
    #2;
    reset = 1'b0;
    #1;
    check("arst_req", {31'd0, imem_bus.imem_req_o}, 32'd0);
    check("arst_valid", {31'd0, ifid_valid_o}, 32'd0);
    check("arst_pc", ifid_pc_o, 32'd0);
    check("arst_instr", ifid_instr_o, 32'd0);
`ifdef IF_FETCH_CNT_EN
    check("arst_cnt", fetch_count, 32'd0);
`endif
    tick();
    reset = 1'b1;
    imem_bus.imem_ready_i = 1'b1;
    stale_en = 1'b1;
    tick();                                  // IDLE ignores the stale word
    stale_en = 1'b0;
    push_exp(32'h0);
    tick();                                  // load RESET_PC word
    imem_bus.imem_ready_i = 1'b0;
    @(negedge clk);
`ifdef IF_FETCH_CNT_EN
    check("post_cnt", fetch_count, 32'd1);
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Safety net: the run is a fixed number of cycles, so this never fires
  // on a healthy design.
  initial begin
    #20000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC loaded on reset (bits [1:0] SHALL be 0).
REQ-002 The block SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 The block SHALL have port reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-004 The block SHALL have port stall_i  input  1  hazard-unit stall; hold PC and IF/ID.
REQ-005 The block SHALL have port redirect_i  input  1  taken branch/jump from EX; flush and reload PC.
REQ-006 The block SHALL have port redirect_pc_i  input  32  target PC for redirect_i.
REQ-007 The block SHALL have port imem_req_o  output  1  instruction-memory request.
REQ-008 The block SHALL have port imem_addr_o  output  32  word-aligned fetch address.
REQ-009 The block SHALL have port imem_ready_i  input  1  imem_rdata_i valid for the outstanding request this cycle.
REQ-010 The block SHALL have port imem_rdata_i  input  32  fetched instruction.
REQ-011 The block SHALL have ports ifid_valid_o (1), ifid_pc_o (32), ifid_pc4_o (32), ifid_instr_o (32)  output  registered IF/ID contents.

Function
REQ-012 FSM states SHALL be IDLE, FETCH, HOLD, DISCARD; IDLE -> FETCH unconditionally on the first clock after reset release.
REQ-013 In FETCH, imem_req_o SHALL be 1 and imem_addr_o SHALL equal PC, held stable until imem_ready_i=1.
REQ-014 FETCH, ready=1, stall_i=0, redirect_i=0: IF/ID SHALL load {valid=1, PC, PC+4, rdata}, PC <= PC+4, stay FETCH (one-cycle latency ready->ifid_valid_o).
REQ-015 FETCH, ready=1, stall_i=1: word SHALL be captured in a 1-entry skid buffer, go HOLD, IF/ID unchanged.
REQ-016 HOLD: imem_req_o SHALL be 0; when stall_i=0, IF/ID SHALL load from skid buffer, PC <= PC+4, go FETCH.
REQ-017 stall_i=1 with no new word: IF/ID and PC SHALL hold; stall_i=0 with no new word: ifid_valid_o SHALL be 0 next cycle (bubble), other IF/ID fields hold.
REQ-018 redirect_i SHALL have priority over stall_i and ready: PC <= {redirect_pc_i[31:2],2'b00}, ifid_valid_o <= 0, skid buffer cleared.
REQ-019 redirect_i in FETCH with ready=0 SHALL go DISCARD; DISCARD keeps old request until ready=1, drops that word, then FETCH at new PC.
REQ-020 redirect_i with ready=1 same cycle SHALL drop the word and stay FETCH at new PC; redirect_i in HOLD or IDLE SHALL go FETCH.
REQ-021 redirect_i during DISCARD SHALL update PC only; state remains DISCARD.
REQ-022 PC+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).

Reset
REQ-023 reset=0 SHALL immediately force PC=RESET_PC, state IDLE, imem_req_o=0, ifid_valid_o=0, ifid_pc_o=ifid_pc4_o=ifid_instr_o=0, skid buffer empty.
REQ-024 Reset asserted mid-request SHALL abandon the request; no word returned afterwards for it is used.

Configuration
REQ-025 With macro IF_FETCH_CNT_EN defined, output fetch_count_o (32) SHALL count IF/ID loads with valid=1, reset to 0, wrap at 2^32.
REQ-026 Without IF_FETCH_CNT_EN, fetch_count_o and its counter SHALL not exist; all other behaviour identical.

Structure
REQ-027 Shared package mips_pkg SHALL hold the FSM state enum, XLEN=32, default RESET_PC, and NOP constant 32'h0000_0000.
REQ-028 IF/ID register SHALL be a sub-module if_id_reg with load, flush (clear valid) and hold controls.

Verification
REQ-029 Reset release, ready=1 every cycle, rdata=addr^32'hA5A5_0000 -> ifid_pc_o 0,4,8,... consecutive cycles, ifid_valid_o=1 from cycle 2.
REQ-030 ready=1 with stall_i=1 for 3 cycles at PC=8 -> IF/ID holds PC=4 entry, imem_req_o=0 in HOLD, then PC=8 word loads first cycle after stall drops.
REQ-031 redirect_i=1, redirect_pc_i=32'h0000_0103 while ready=0 -> DISCARD, old word dropped, next imem_addr_o=32'h0000_0100, ifid_valid_o=0 meanwhile.
REQ-032 redirect_i and stall_i both 1 with ready=1 -> flush wins: ifid_valid_o=0, PC=target, word dropped.
REQ-033 redirect to 32'hFFFF_FFFC, ready=1 -> ifid_pc4_o=0, next imem_addr_o=0.
REQ-034 reset=0 mid-request, rdata returned after release -> IF/ID valid only for fetch at RESET_PC; with IF_FETCH_CNT_EN fetch_count_o=0 after reset.
